path_mem_arbiter: RTL and testbench

Shares one single-port path memory (64x32, registered read) between two requesters, e.g. the floyd_warshall kernel and a host loader/checker. Round-robin arbitration with a combinational same-cycle grant. Each read is tagged with its requester ID so that read data returns only to the issuer after the memory read latency. Sits between the kernels and the memref_rd/memref_wr memory models in the testbenches and, later, in synthesized top levels.

---
 rtl/path_arb_pkg.sv | 41 ++++
 rtl/path_arb_rd_tracker.sv | 41 ++++
 rtl/path_mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_path_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/path_arb_pkg.sv
// Shared types and constants for the path memory arbiter.
// The arbiter and its read-tag delay line both import this package.
package path_arb_pkg;

    // Default geometry of the shared path memory (64 x 32).
    localparam int PATH_ADDR_W = 6;
    localparam int PATH_DATA_W = 32;

    // Deepest read latency the tag delay line is meant to cover.
    localparam int RD_LATENCY_MAX = 4;

    // Requester identifier: 0 = requester 0, 1 = requester 1.
    typedef logic req_id_t;

    // One slot of the read tracker: is a read in flight, and who issued it.
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;

    // Round-robin choice between two requesters. On a tie the requester
    // that was not granted last wins; with a single request that requester
    // wins; with no request the result is unused by the caller.
    function automatic req_id_t rr_pick(
        input logic    req0,
        input logic    req1,
        input req_id_t last_gnt
    );
        req_id_t pick;
        pick = last_gnt;
        if (req0 && req1) begin
            pick = ~last_gnt;
        end else if (req0) begin
            pick = 1'b0;
        end else if (req1) begin
            pick = 1'b1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/path_arb_rd_tracker.sv
// Read-tag delay line: carries {valid, id} for every granted access so
// the read data can be routed back to its issuer when the memory answers.
// DEPTH equals the memory read latency (1..RD_LATENCY_MAX).
module path_arb_rd_tracker
    import path_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t push_tag_i,
    output rd_tag_t tail_tag_o
);

    rd_tag_t [DEPTH-1:0] pipe_q;
    rd_tag_t [DEPTH-1:0] pipe_d;

    // Shift every slot one step towards the tail, new tag enters at slot 0.
    always_comb begin
        pipe_d[0] = push_tag_i;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Tag register stages.
    // NOTE: every slot is reset, not just the valid bits' consumer; clearing
    // the whole line is what drops in-flight reads when reset hits mid-flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_q <= '0;
        end else begin
            // NOTE: non-blocking so each stage captures its neighbour's
            // pre-edge value; blocking here would collapse the delay line.
            pipe_q <= pipe_d;
        end
    end

    assign tail_tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/path_mem_arbiter.sv
// Two-requester round-robin arbiter in front of one single-port path memory.
// Grants are combinational (same cycle as the request); read data returns
// RD_LATENCY cycles later, flagged only to the requester that issued it.
// Optional feature macro: PATH_ARB_LOCK_EN adds r0_lock/r1_lock so one
// requester can hold the memory across a read-compare-write sequence.
module path_mem_arbiter
    import path_arb_pkg::*;
#(
    parameter int ADDR_W     = PATH_ADDR_W,
    parameter int DATA_W     = PATH_DATA_W,
    parameter int RD_LATENCY = 1            // legal range 1..RD_LATENCY_MAX
) (
    input  logic              clk,
    input  logic              rst,
`ifdef PATH_ARB_LOCK_EN
    input  logic              r0_lock,
    input  logic              r1_lock,
`endif
    // requester 0
    input  logic              r0_en,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    // requester 1
    input  logic              r1_en,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    // memory side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Round-robin history: which requester got the most recent grant.
    req_id_t last_gnt_q;
    req_id_t last_gnt_d;

    // Requests that survive lock masking and may compete for the memory.
    logic    req0;
    logic    req1;

    logic    gnt_any;
    req_id_t gnt_id;

    rd_tag_t push_tag;
    rd_tag_t tail_tag;

`ifdef PATH_ARB_LOCK_EN
    // Lock ownership: valid flag plus owning requester.
    logic    lock_vld_q;
    logic    lock_vld_d;
    req_id_t lock_own_q;
    req_id_t lock_own_d;
    logic    lock_held;
    logic    gnt_lock;

    // The lock stays in force only while the owner keeps asserting it;
    // dropping lock releases the memory in that same cycle.
    assign lock_held = lock_vld_q && (lock_own_q ? r1_lock : r0_lock);

    // Mask the non-owner while the lock is held, regardless of priority.
    always_comb begin
        req0 = r0_en && !(lock_held && (lock_own_q == 1'b1));
        req1 = r1_en && !(lock_held && (lock_own_q == 1'b0));
    end
`else
    assign req0 = r0_en;
    assign req1 = r1_en;
`endif

    // Grant selection, memory mux and read-tag generation.
    // NOTE: every output of this block gets a default first, so no path
    // through the ifs leaves a signal unassigned and no latch is inferred.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_id    = rr_pick(req0, req1, last_gnt_q);
        r0_gnt    = 1'b0;
        r1_gnt    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        // Reset is applied combinationally too, so nothing is granted
        // while rst is held low even though requests may be present.
        if (rst && (req0 || req1)) begin
            gnt_any = 1'b1;
            mem_en  = 1'b1;
            if (gnt_id == 1'b0) begin
                r0_gnt    = 1'b1;
                mem_we    = r0_we;
                mem_addr  = r0_addr;
                mem_wdata = r0_wdata;
            end else begin
                r1_gnt    = 1'b1;
                mem_we    = r1_we;
                mem_addr  = r1_addr;
                mem_wdata = r1_wdata;
            end
        end

        // Only granted reads produce a response; writes are fire-and-forget.
        push_tag.valid = gnt_any && !mem_we;
        push_tag.id    = gnt_id;

        // History advances only on cycles that actually grant something.
        last_gnt_d = gnt_any ? gnt_id : last_gnt_q;
    end

    // Round-robin history register; after reset the first tie goes to r0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

`ifdef PATH_ARB_LOCK_EN
    // Lock owner next state: hold while the owner keeps lock, otherwise a
    // requester granted with its lock input high takes ownership.
    always_comb begin
        gnt_lock   = gnt_id ? r1_lock : r0_lock;
        lock_vld_d = 1'b0;
        lock_own_d = lock_own_q;
        if (lock_held) begin
            lock_vld_d = 1'b1;
        end else if (gnt_any && gnt_lock) begin
            lock_vld_d = 1'b1;
            lock_own_d = gnt_id;
        end
    end

    // Lock owner register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_vld_q <= 1'b0;
            lock_own_q <= 1'b0;
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
        end
    end
`endif

    // Tag delay line matched to the memory read latency.
    path_arb_rd_tracker #(
        .DEPTH (RD_LATENCY)
    ) u_rd_tracker (
        .clk        (clk),
        .rst        (rst),
        .push_tag_i (push_tag),
        .tail_tag_o (tail_tag)
    );

    // Read data is broadcast; rvalid says whose it is.
    assign r0_rvalid = tail_tag.valid && (tail_tag.id == 1'b0);
    assign r1_rvalid = tail_tag.valid && (tail_tag.id == 1'b1);
    assign r0_rdata  = mem_rdata;
    assign r1_rdata  = mem_rdata;

endmodule

// File: tb/tb_path_mem_arbiter.sv
// Self-checking bench for path_mem_arbiter. Two instances share one
// stimulus stream: u_dut_a with read latency 1 and u_dut_b with latency 3,
// each backed by its own memory model and its own return scoreboard.
// Build with PATH_ARB_LOCK_EN defined to also exercise the lock feature.
module tb_path_mem_arbiter;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          due;
    } sb_t;

    logic clk;
    logic rst;

    logic        r0_en, r0_we, r1_en, r1_we;
    logic [5:0]  r0_addr, r1_addr;
    logic [31:0] r0_wdata, r1_wdata;
`ifdef PATH_ARB_LOCK_EN
    logic        r0_lock, r1_lock;
`endif

    logic        a_r0_gnt, a_r0_rvalid, a_r1_gnt, a_r1_rvalid;
    logic [31:0] a_r0_rdata, a_r1_rdata;
    logic        a_mem_en, a_mem_we;
    logic [5:0]  a_mem_addr;
    logic [31:0] a_mem_wdata, a_mem_rdata;

    logic        b_r0_gnt, b_r0_rvalid, b_r1_gnt, b_r1_rvalid;
    logic [31:0] b_r0_rdata, b_r1_rdata;
    logic        b_mem_en, b_mem_we;
    logic [5:0]  b_mem_addr;
    logic [31:0] b_mem_wdata, b_mem_rdata;

    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    logic [31:0] rd_a;
    logic [31:0] rd_b0, rd_b1, rd_b2;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    sb_t qa[$];
    sb_t qb[$];

    path_mem_arbiter #(.ADDR_W(6), .DATA_W(32), .RD_LATENCY(LAT_A)) u_dut_a (
        .clk(clk), .rst(rst),
`ifdef PATH_ARB_LOCK_EN
        .r0_lock(r0_lock), .r1_lock(r1_lock),
`endif
        .r0_en(r0_en), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(a_r0_gnt), .r0_rvalid(a_r0_rvalid), .r0_rdata(a_r0_rdata),
        .r1_en(r1_en), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(a_r1_gnt), .r1_rvalid(a_r1_rvalid), .r1_rdata(a_r1_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    path_mem_arbiter #(.ADDR_W(6), .DATA_W(32), .RD_LATENCY(LAT_B)) u_dut_b (
        .clk(clk), .rst(rst),
`ifdef PATH_ARB_LOCK_EN
        .r0_lock(r0_lock), .r1_lock(r1_lock),
`endif
        .r0_en(r0_en), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(b_r0_gnt), .r0_rvalid(b_r0_rvalid), .r0_rdata(b_r0_rdata),
        .r1_en(r1_en), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(b_r1_gnt), .r1_rvalid(b_r1_rvalid), .r1_rdata(b_r1_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: path[i] = i+1 except path[32] = 0, loaded on the first edge.
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 64; i++) mem_a[i] <= (i == 32) ? 32'd0 : 32'(i + 1);
        end else if (a_mem_en && a_mem_we) begin
            mem_a[a_mem_addr] <= a_mem_wdata;
        end
        if (a_mem_en && !a_mem_we) rd_a <= mem_a[a_mem_addr];
    end
    assign a_mem_rdata = rd_a;

    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 64; i++) mem_b[i] <= (i == 32) ? 32'd0 : 32'(i + 1);
        end else if (b_mem_en && b_mem_we) begin
            mem_b[b_mem_addr] <= b_mem_wdata;
        end
        if (b_mem_en && !b_mem_we) rd_b0 <= mem_b[b_mem_addr];
        rd_b1 <= rd_b0;
        rd_b2 <= rd_b1;
    end
    assign b_mem_rdata = rd_b2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Return monitors: pop the scoreboard on each rvalid, flag overdue entries.
    always @(negedge clk) begin
        sb_t e;
        if (a_r0_rvalid || a_r1_rvalid) begin
            if (qa.size() == 0) begin
                check("a_spurious_rvalid", {a_r1_rvalid, a_r0_rvalid}, 2'b00);
            end else begin
                e = qa.pop_front();
                check("a_rv_dual", a_r0_rvalid & a_r1_rvalid, 1'b0);
                check("a_rv_id", a_r1_rvalid, e.id);
                check("a_rdata", e.id ? a_r1_rdata : a_r0_rdata, e.data);
                check("a_rv_cycle", cyc, e.due);
            end
        end
        if (qa.size() != 0 && qa[0].due < cyc) begin
            e = qa.pop_front();
            check("a_rv_missing_cycle", cyc, e.due);
        end
    end

    always @(negedge clk) begin
        sb_t e;
        if (b_r0_rvalid || b_r1_rvalid) begin
            if (qb.size() == 0) begin
                check("b_spurious_rvalid", {b_r1_rvalid, b_r0_rvalid}, 2'b00);
            end else begin
                e = qb.pop_front();
                check("b_rv_dual", b_r0_rvalid & b_r1_rvalid, 1'b0);
                check("b_rv_id", b_r1_rvalid, e.id);
                check("b_rdata", e.id ? b_r1_rdata : b_r0_rdata, e.data);
                check("b_rv_cycle", cyc, e.due);
            end
        end
        if (qb.size() != 0 && qb[0].due < cyc) begin
            e = qb.pop_front();
            check("b_rv_missing_cycle", cyc, e.due);
        end
    end

    task automatic drive(input logic e0, input logic w0, input logic [5:0] a0, input logic [31:0] d0,
                         input logic e1, input logic w1, input logic [5:0] a1, input logic [31:0] d1);
        r0_en = e0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
        r1_en = e1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
    endtask

    // One clock of traffic: check expected grants and memory drive on both
    // instances, then queue the expected read return (data ed) if any.
    task automatic cycle(input logic eg0, input logic eg1, input logic pa, input logic pb,
                         input logic [31:0] ed);
        logic [5:0]  ea;
        logic        ew;
        logic [31:0] ewd;
        sb_t         e;
        @(negedge clk);
        ea  = eg0 ? r0_addr  : (eg1 ? r1_addr  : 6'd0);
        ew  = eg0 ? r0_we    : (eg1 ? r1_we    : 1'b0);
        ewd = eg0 ? r0_wdata : (eg1 ? r1_wdata : 32'd0);
        check("a_r0_gnt", a_r0_gnt, eg0);
        check("a_r1_gnt", a_r1_gnt, eg1);
        check("b_r0_gnt", b_r0_gnt, eg0);
        check("b_r1_gnt", b_r1_gnt, eg1);
        check("a_mem_en", a_mem_en, eg0 | eg1);
        check("b_mem_en", b_mem_en, eg0 | eg1);
        check("a_mem_we", a_mem_we, ew);
        check("a_mem_addr", a_mem_addr, ea);
        check("a_mem_wdata", a_mem_wdata, ewd);
        check("b_mem_addr", b_mem_addr, ea);
        e.id   = eg1;
        e.data = ed;
        if (pa) begin e.due = cyc + LAT_A; qa.push_back(e); end
        if (pb) begin e.due = cyc + LAT_B; qb.push_back(e); end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 6'd0, 32'd0, 0, 0, 6'd0, 32'd0);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 32'd0);
    endtask

    task automatic do_reset();
        drive(0, 0, 6'd0, 32'd0, 0, 0, 6'd0, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
`ifdef PATH_ARB_LOCK_EN
        r0_lock = 1'b0;
        r1_lock = 1'b0;
`endif
        // Reset state: requests present but nothing may be granted or driven.
        rst = 1'b0;
        drive(1, 0, 6'd5, 32'h1234, 1, 1, 6'd6, 32'h5678);
        @(negedge clk);
        check("rst_a_r0_gnt", a_r0_gnt, 1'b0);
        check("rst_a_r1_gnt", a_r1_gnt, 1'b0);
        check("rst_b_r1_gnt", b_r1_gnt, 1'b0);
        check("rst_a_mem_en", a_mem_en, 1'b0);
        check("rst_a_mem_we", a_mem_we, 1'b0);
        check("rst_a_mem_addr", a_mem_addr, 6'd0);
        check("rst_a_mem_wdata", a_mem_wdata, 32'd0);
        check("rst_rvalid", {a_r0_rvalid, a_r1_rvalid, b_r0_rvalid, b_r1_rvalid}, 4'b0000);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(1);

        // 1: single requester reads addr 32 then addr 5.
        drive(1, 0, 6'd32, 32'd0, 0, 0, 6'd0, 32'd0);
        cycle(1, 0, 1, 1, 32'd0);
        drive(1, 0, 6'd5, 32'd0, 0, 0, 6'd0, 32'd0);
        cycle(1, 0, 1, 1, 32'd6);
        idle(4);

        // 2: contention from reset, both requesters held for 4 cycles.
        do_reset();
        drive(1, 0, 6'd1, 32'd0, 1, 0, 6'd2, 32'd0);
        cycle(1, 0, 1, 1, 32'd2);
        cycle(0, 1, 1, 1, 32'd3);
        cycle(1, 0, 1, 1, 32'd2);
        cycle(0, 1, 1, 1, 32'd3);
        idle(4);

        // 3: write then read of the same address on the next cycle.
        drive(0, 0, 6'd0, 32'd0, 1, 1, 6'd10, 32'hDEAD);
        cycle(0, 1, 0, 0, 32'd0);
        drive(1, 0, 6'd10, 32'd0, 0, 0, 6'd0, 32'd0);
        cycle(1, 0, 1, 1, 32'hDEAD);
        idle(4);

        // 4: interleaved back-to-back reads (latency 1 and 3 instances).
        drive(1, 0, 6'd3, 32'd0, 0, 0, 6'd0, 32'd0);
        cycle(1, 0, 1, 1, 32'd4);
        drive(1, 0, 6'd4, 32'd0, 1, 0, 6'd20, 32'd0);
        cycle(0, 1, 1, 1, 32'd21);
        drive(1, 0, 6'd4, 32'd0, 1, 0, 6'd33, 32'd0);
        cycle(1, 0, 1, 1, 32'd5);
        drive(0, 0, 6'd0, 32'd0, 1, 0, 6'd33, 32'd0);
        cycle(0, 1, 1, 1, 32'd34);
        drive(1, 0, 6'd32, 32'd0, 0, 0, 6'd0, 32'd0);
        cycle(1, 0, 1, 1, 32'd0);
        idle(5);

        // 5: reset while the latency-3 read is in flight; it must vanish.
        drive(1, 0, 6'd9, 32'd0, 0, 0, 6'd0, 32'd0);
        cycle(1, 0, 1, 0, 32'd10);
        drive(0, 0, 6'd0, 32'd0, 0, 0, 6'd0, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1, 0, 6'd11, 32'd0, 1, 0, 6'd12, 32'd0);
        cycle(1, 0, 1, 1, 32'd12);
        idle(5);

`ifdef PATH_ARB_LOCK_EN
        // 6: r0 holds the lock across read / idle / write; r1 waits.
        do_reset();
        r0_lock = 1'b1;
        drive(1, 0, 6'd7, 32'd0, 1, 0, 6'd7, 32'd0);
        cycle(1, 0, 1, 1, 32'd8);
        drive(0, 0, 6'd0, 32'd0, 1, 0, 6'd7, 32'd0);
        cycle(0, 0, 0, 0, 32'd0);
        drive(1, 1, 6'd7, 32'd3, 1, 0, 6'd7, 32'd0);
        cycle(1, 0, 0, 0, 32'd0);
        r0_lock = 1'b0;
        drive(0, 0, 6'd0, 32'd0, 1, 0, 6'd7, 32'd0);
        cycle(0, 1, 1, 1, 32'd3);
        idle(5);
`endif

        check("a_queue_drained", qa.size(), 32'd0);
        check("b_queue_drained", qb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
